// File: rtl/csa_accum_ctrl.sv
// Carry-save operand accumulator: sums num_ops unsigned operands with no carry chain in the loop,
// one carry-propagate add in RESOLVE; result held under valid/ready until the consumer takes it.
module csa_accum_ctrl #(
  parameter  int W  = 4,
  parameter  int CW = 4,
  localparam int AW = W + CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] num_ops,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] remaining;
  logic [AW-1:0] sum_r;
  logic [AW-1:0] carry_r;

  logic [AW-1:0] x;
  logic [AW-1:0] csa_sum;
  logic [AW-1:0] csa_carry;

  // sum_r + carry_r always equals the running total (mod 2^AW)
  assign x         = {{CW{1'b0}}, in_data};
  assign csa_sum   = sum_r ^ carry_r ^ x;
  assign csa_carry = ((sum_r & carry_r) | (sum_r & x) | (carry_r & x)) << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      sum_r     <= '0;
      carry_r   <= '0;
      out_sum   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_ops != '0) begin
              state     <= ACCUM;
              remaining <= num_ops;
              sum_r     <= '0;
              carry_r   <= '0;
              in_ready  <= 1'b1;
            end else begin
              state     <= DONE;
              out_sum   <= '0;
              out_valid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            sum_r     <= csa_sum;
            carry_r   <= csa_carry;
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          out_sum   <= sum_r + carry_r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // start is deliberately not looked at here, even on the handshake edge
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboarded bench for csa_accum_ctrl: directed jobs push expected sums, a negedge monitor checks handshakes.
module tb_csa_accum_ctrl;
  localparam int W  = 4;
  localparam int CW = 4;
  localparam int AW = W + CW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_ops;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  csa_accum_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a handshake completes on the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %0d expected none at %0t", out_sum, $time);
      end else begin
        check("out_sum", out_sum, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [CW-1:0] n);
    start   = 1'b1;
    num_ops = n;
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input int gap);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("valid_timeout", out_valid, 1);
  endtask

  task automatic drain();
    wait_valid();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_handshake", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_ops = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_sum", out_sum, 0);

    // 5+9+14 back to back, latency observed edge by edge
    exp_q.push_back(8'd28);
    start_job(4'd3);
    check("accum_in_ready", in_ready, 1);
    send(4'd5, 0); send(4'd9, 0); send(4'd14, 0);
    check("resolve_out_valid", out_valid, 0);
    check("resolve_in_ready", in_ready, 0);
    check("resolve_busy", busy, 1);
    tick();
    check("done_out_valid", out_valid, 1);
    check("done_sum_28", out_sum, 28);
    drain();

    // full-scale job: 15 * 15
    exp_q.push_back(8'd225);
    start_job(4'd15);
    for (int i = 0; i < 15; i++) send(4'hF, 0);
    drain();

    // zero-operand job goes straight to DONE
    exp_q.push_back(8'd0);
    start_job(4'd0);
    check("zero_out_valid", out_valid, 1);
    check("zero_in_ready", in_ready, 0);
    check("zero_out_sum", out_sum, 0);
    drain();

    // gapped operands, consumer stalls five cycles
    exp_q.push_back(8'd17);
    start_job(4'd2);
    send(4'd6, 3);
    check("gap_in_ready", in_ready, 1);
    send(4'd11, 3);
    for (int i = 0; i < 5; i++) begin
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_busy", busy, 1);
      check("hold_out_sum", out_sum, 17);
      tick();
    end
    drain();

    // reset mid-job, asserted together with start; abandoned job yields nothing
    start_job(4'd4);
    send(4'd7, 0); send(4'd8, 0);
    rst = 1'b1; start = 1'b1; num_ops = 4'd1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_sum", out_sum, 0);
    exp_q.push_back(8'd10);
    start_job(4'd4);
    send(4'd1, 0); send(4'd2, 0); send(4'd3, 0); send(4'd4, 0);
    drain();

    // start in ACCUM and on the DONE handshake edge is ignored
    exp_q.push_back(8'd7);
    start_job(4'd2);
    send(4'd3, 0);
    start = 1'b1; num_ops = 4'd5;
    tick();
    start = 1'b0;
    send(4'd4, 0);
    wait_valid();
    out_ready = 1'b1; start = 1'b1; num_ops = 4'd1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    check("ign_start_busy", busy, 0);
    tick();
    check("ign_start_still_idle", busy, 0);
    check("ign_start_no_valid", out_valid, 0);

    // in_valid while idle must not leak into the next job
    in_valid = 1'b1; in_data = 4'd9;
    tick(); tick();
    in_valid = 1'b0;
    check("idle_in_valid_busy", busy, 0);
    exp_q.push_back(8'd2);
    start_job(4'd1);
    send(4'd2, 0);
    drain();

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
